// File: rtl/approx_pkg.sv
`default_nettype none
// approx_pkg -- shared defaults, k-clamp helper and stage-1 payload type (rev 1.0)
package approx_pkg;

  localparam int W_DEF     = 16;
  localparam int P_MAX_DEF = 8;
  localparam int MAX_W     = 64;

  // Fields are sized for the widest legal operand; unused upper bits stay zero.
  typedef struct packed {
    logic [MAX_W-1:0] y_lo;
    logic             carry;
    logic [MAX_W-1:0] a_hi;
    logic [MAX_W-1:0] b_hi;
  } s1_payload_t;

  function automatic int clamp_k(input int k, input int p_max);
    return (k > p_max) ? p_max : k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_seg.sv
`default_nettype none
// approx_seg -- combinational segment adder: bits below k are OR-approximated, the rest ripple exactly (rev 1.0)
module approx_seg
  import approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(k)) begin
        // Approximated bit: no carry chain, but the last one seeds the exact part.
        sum[i] = a[i] | b[i];
        c      = a[i] & b[i];
      end else begin
        sum[i] = a[i] ^ b[i] ^ c;
        c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    cout = c;
  end

endmodule
`default_nettype wire

// File: rtl/approx_adder_pipe.sv
`default_nettype none
// approx_adder_pipe -- two-stage approximate adder with valid/ready handshakes (rev 1.0)
// Optional error statistics (err_abs, err_acc, stats_clr) when APPROX_ERR_STATS_EN is defined.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int  W     = W_DEF,
  parameter int  P_MAX = P_MAX_DEF,
  parameter int  SPLIT = W / 2,
  localparam int KW    = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] approx_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    y,
`ifdef APPROX_ERR_STATS_EN
  output logic [W:0]    err_abs,
  output logic [31:0]   err_acc,
  input  logic          stats_clr,
`endif
  output logic [15:0]   tx_cnt
);

  localparam int HW = W - SPLIT;

  logic          s1_valid;
  logic          s2_adv;
  logic          out_hs;
  logic [KW-1:0] k_eff;
  s1_payload_t   s1_d;
  s1_payload_t   s1_q;
  logic [SPLIT-1:0] lo_sum;
  logic          lo_cout;
  logic [HW-1:0] hi_sum;
  logic          hi_cout;
  logic [W:0]    y_next;
  logic          unused_pad;

  // Stage 1 can only advance together with stage 2, so in_ready never looks at in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign out_hs   = out_valid && out_ready;

  assign k_eff = KW'(clamp_k(int'(approx_k), P_MAX));

  approx_seg #(.WIDTH(SPLIT), .KW(KW)) u_seg_lo (
    .a    (a[SPLIT-1:0]),
    .b    (b[SPLIT-1:0]),
    .k    (k_eff),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.y_lo  = MAX_W'(lo_sum);
    s1_d.carry = lo_cout;
    s1_d.a_hi  = MAX_W'(a[W-1:SPLIT]);
    s1_d.b_hi  = MAX_W'(b[W-1:SPLIT]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Upper segment is always exact; k never reaches past SPLIT.
  approx_seg #(.WIDTH(HW), .KW(1)) u_seg_hi (
    .a    (s1_q.a_hi[HW-1:0]),
    .b    (s1_q.b_hi[HW-1:0]),
    .k    (1'b0),
    .cin  (s1_q.carry),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign y_next     = {hi_cout, hi_sum, s1_q.y_lo[SPLIT-1:0]};
  assign unused_pad = ^{s1_q.y_lo[MAX_W-1:SPLIT], s1_q.a_hi[MAX_W-1:HW], s1_q.b_hi[MAX_W-1:HW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) y <= y_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         tx_cnt <= '0;
    else if (out_hs) tx_cnt <= tx_cnt + 16'd1;
  end

`ifdef APPROX_ERR_STATS_EN
  localparam int AW = ((W + 1 > 32) ? W + 1 : 32) + 1;

  logic [W:0]    exact_s1;
  logic [W:0]    err_next;
  logic [AW-1:0] acc_sum;
  logic [AW-1:0] clr_val;

  function automatic logic [31:0] sat32(input logic [AW-1:0] v);
    return (v > AW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                        exact_s1 <= '0;
    else if (in_valid && in_ready)  exact_s1 <= {1'b0, a} + {1'b0, b};
  end

  assign err_next = (exact_s1 >= y_next) ? (exact_s1 - y_next) : (y_next - exact_s1);

  always_ff @(posedge clk) begin
    if (rst)                       err_abs <= '0;
    else if (s2_adv && s1_valid)   err_abs <= err_next;
  end

  assign acc_sum = AW'(err_acc) + AW'(err_abs);
  assign clr_val = out_hs ? AW'(err_abs) : '0;

  always_ff @(posedge clk) begin
    if (rst)            err_acc <= '0;
    else if (stats_clr) err_acc <= sat32(clr_val);
    else if (out_hs)    err_acc <= sat32(acc_sum);
  end
`else
  // Without statistics only the approximate datapath exists.
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe.sv
`default_nettype none
// tb_approx_adder_pipe -- directed and random checks of approx_adder_pipe against an arithmetic model.
module tb_approx_adder_pipe;

  localparam int W     = 16;
  localparam int P_MAX = 8;
  localparam int KW    = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [KW-1:0] approx_k;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    y;
  logic [15:0]   tx_cnt;
`ifdef APPROX_ERR_STATS_EN
  logic [W:0]    err_abs;
  logic [31:0]   err_acc;
  logic          stats_clr;
  logic [31:0]   acc_model;
`endif

  typedef struct {
    logic [W:0] y;
    logic [W:0] err;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         n_tx;
  int         idx;
  logic       prev_stall;
  logic [W:0] prev_y;
  logic       last_acc;
  logic [15:0] bp_a [4];
  logic [15:0] bp_b [4];
  int          bp_k [4];

  always #5 clk = ~clk;

  approx_adder_pipe #(.W(W), .P_MAX(P_MAX), .SPLIT(W / 2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_k  (approx_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef APPROX_ERR_STATS_EN
    .err_abs   (err_abs),
    .err_acc   (err_acc),
    .stats_clr (stats_clr),
`endif
    .tx_cnt    (tx_cnt)
  );

  // Approximate sum from the arithmetic definition: OR below k, exact add of the
  // shifted-down upper parts plus the carry generated at bit k-1.
  function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb, input int kreq);
    exp_t e;
    int k;
    longint unsigned ua, ub, lo, c, hi, apx, ex;
    ua  = 64'(aa);
    ub  = 64'(bb);
    k   = (kreq > P_MAX) ? P_MAX : kreq;
    lo  = (ua | ub) & ((64'd1 << k) - 64'd1);
    c   = (k > 0) ? ((ua >> (k - 1)) & (ub >> (k - 1)) & 64'd1) : 64'd0;
    hi  = (ua >> k) + (ub >> k) + c;
    apx = (hi << k) | lo;
    ex  = ua + ub;
    e.y   = 17'(apx);
    e.err = 17'((ex > apx) ? (ex - apx) : (apx - ex));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs were driven at the falling edge; settle, score, advance.
  task automatic cycle();
    exp_t e;
    longint s;
    #1;
    if (prev_stall) begin
      chk("hold_y", 64'(y), 64'(prev_y));
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
`ifdef APPROX_ERR_STATS_EN
    chk("err_acc", 64'(err_acc), 64'(acc_model));
`endif
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(model(a, b, int'(approx_k)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("y", 64'(y), 64'(e.y));
        n_tx++;
`ifdef APPROX_ERR_STATS_EN
        chk("err_abs", 64'(err_abs), 64'(e.err));
        s = longint'(acc_model) + longint'(e.err);
        if (stats_clr) acc_model = 32'(e.err);
        else           acc_model = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
`endif
      end
    end
`ifdef APPROX_ERR_STATS_EN
    else if (stats_clr) acc_model = '0;
`endif
    s = 0;
    prev_stall = out_valid && !out_ready;
    prev_y     = y;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    approx_k  = '0;
`ifdef APPROX_ERR_STATS_EN
    stats_clr = 1'b0;
    acc_model = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    exp_q.delete();
    n_tx       = 0;
    prev_stall = 1'b0;
  endtask

  // One isolated beat: checks acceptance, 2-cycle latency and the expected result.
  task automatic single(input logic [15:0] aa, input logic [15:0] bb, input int kk,
                        input logic [16:0] expy, input logic [16:0] experr,
                        input bit clr, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = aa;
    b         = bb;
    approx_k  = KW'(kk);
    cycle();
    chk({tag, "_accept"}, 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cycle();
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(y), 64'(expy));
`ifdef APPROX_ERR_STATS_EN
    chk({tag, "_err"}, 64'(err_abs), 64'(experr));
    stats_clr = clr;
`else
    if (clr) chk({tag, "_err_unused"}, 64'(experr), 64'(experr) & 64'h1FFFF);
`endif
    cycle();
`ifdef APPROX_ERR_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_tx_cnt", 64'(tx_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    single(16'h1234, 16'h0FFF, 0,  17'h02233, 17'd0, 1'b0, "k0_basic");
    single(16'h0008, 16'h0008, 4,  17'h00018, 17'd8, 1'b0, "k4_over");
    single(16'h000F, 16'h0001, 4,  17'h0000F, 17'd1, 1'b0, "k4_under");
    single(16'h00FF, 16'h0001, 12, 17'h000FF, 17'd1, 1'b0, "k12_clamp");
    single(16'hFFFF, 16'hFFFF, 0,  17'h1FFFE, 17'd0, 1'b0, "k0_max");

    // Backpressure: 4 back-to-back beats against a stalled sink.
    do_reset();
    bp_a = '{16'h0011, 16'h1234, 16'hFF00, 16'h8001};
    bp_b = '{16'h0022, 16'h4321, 16'h01FF, 16'h8001};
    bp_k = '{0, 3, 8, 16};
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = bp_a[idx]; b = bp_b[idx]; approx_k = KW'(bp_k[idx]);
      end
      cycle();
      if (last_acc) idx++;
    end
    chk("bp_accepted_stalled", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = bp_a[idx]; b = bp_b[idx]; approx_k = KW'(bp_k[idx]);
      end
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_tx_cnt", 64'(tx_cnt), 64'd4);

    // Reset with the pipeline full and a simultaneous handshake attempt.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h5555; b = 16'h3333; approx_k = '0;
    cycle();
    cycle();
    chk("pre_rst_full", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete(); n_tx = 0; prev_stall = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_tx_cnt", 64'(tx_cnt), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_y", 64'(y), 64'd0);
`ifdef APPROX_ERR_STATS_EN
    acc_model = '0;
    chk("mid_rst_err_acc", 64'(err_acc), 64'd0);
`endif
    @(negedge clk);
    single(16'h00FF, 16'h0001, 0, 17'h00100, 17'd0, 1'b0, "post_rst");

`ifdef APPROX_ERR_STATS_EN
    force dut.err_acc = 32'hFFFF_FFFA;
    @(negedge clk);
    release dut.err_acc;
    acc_model = 32'hFFFF_FFFA;
    single(16'h0008, 16'h0008, 4, 17'h00018, 17'd8, 1'b0, "sat_beat");
    chk("sat_acc", 64'(err_acc), 64'hFFFF_FFFF);
    single(16'h000F, 16'h0001, 4, 17'h0000F, 17'd1, 1'b1, "clr_beat");
    chk("clr_acc", 64'(err_acc), 64'd1);
`endif

    // Random traffic with random backpressure against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      approx_k  = KW'($urandom_range(0, 20));
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) cycle();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_tx_cnt", 64'(tx_cnt), 64'(16'(n_tx)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_adder_pipe.md
APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

Interface
REQ-001 Parameter W, default 16: operand width in bits (4..64).
REQ-002 Parameter P_MAX, default 8: maximum approximated LSB count; P_MAX <= SPLIT.
REQ-003 Parameter SPLIT, default W/2: bit index separating pipeline stage 1 (lower) from stage 2 (upper).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand beat valid.
REQ-007 in_ready  out  1  block accepts beat when in_valid & in_ready.
REQ-008 a, b  in  W each  operands, unsigned.
REQ-009 approx_k  in  $clog2(W+1)  requested approximated LSB count, sampled with the beat.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-012 y  out  W+1  approximate sum including carry-out MSB.
REQ-013 tx_cnt  out  16  completed output handshakes, wraps 0xFFFF->0.

Function
REQ-014 Effective k SHALL be min(approx_k, P_MAX), fixed per beat at acceptance.
REQ-015 Bits i<k: y[i] = a[i] | b[i]; no carry propagation among these bits.
REQ-016 Carry into bit k: a[k-1] & b[k-1] if k>0, else 0.
REQ-017 Bits k..W-1: exact ripple/lookahead addition; y[W] = final carry-out.
REQ-018 k=0 SHALL yield the exact sum a+b.
REQ-019 Stage 1 registers y[SPLIT-1:0], carry into bit SPLIT, and a/b upper halves; stage 2 computes y[W:SPLIT].
REQ-020 Latency: exactly 2 cycles from accepting handshake to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-021 Stage 2 advances when !out_valid | out_ready; stage 1 advances when stage 2 advances or stage 2 empty.
REQ-022 in_ready = !s1_valid | stage-1 advance; combinational from out_ready only (no in_valid dependency).
REQ-023 While out_valid & !out_ready, y and all output sideband SHALL hold stable.
REQ-024 Beats SHALL exit in acceptance order; no drop, no duplication.
REQ-025 tx_cnt increments once per output handshake.

Reset
REQ-026 On rst: s1_valid=0, out_valid=0, y=0, tx_cnt=0, in_ready=1 next cycle; in-flight beats discarded.
REQ-027 rst asserted mid-transfer SHALL override any simultaneous handshake.

Configuration
REQ-028 Macro APPROX_ERR_STATS_EN: when defined, add ports err_abs out W+1, err_acc out 32, stats_clr in 1.
REQ-029 With macro: exact sum computed alongside; err_abs = |exact - y|, aligned with y, held under backpressure.
REQ-030 With macro: err_acc += err_abs per output handshake, saturating at 0xFFFFFFFF; stats_clr loads err_acc with current-beat err_abs if handshake else 0; reset clears to 0.
REQ-031 Without macro: ports and exact-sum logic absent; y timing identical.

Structure
REQ-032 Package approx_pkg holds the default W/P_MAX constants, the k-clamp function, and the stage-1 payload struct typedef.
REQ-033 One sub-module approx_seg (combinational segment adder: width, k, carry-in -> sum, carry-out) instantiated per stage.

Verification (W=16, P_MAX=8)
REQ-034 k=0, a=0x1234, b=0x0FFF -> y=0x02233 two cycles after accept; err_abs=0.
REQ-035 k=4, a=0x0008, b=0x0008 -> y=0x00018, err_abs=8; k=4, a=0x000F, b=0x0001 -> y=0x0000F, err_abs=1.
REQ-036 k=12 (clamped 8), a=0x00FF, b=0x0001 -> y=0x000FF, err_abs=1; k=0, a=b=0xFFFF -> y=0x1FFFE.
REQ-037 Backpressure: 4 back-to-back beats, out_ready low 5 cycles -> in_ready low after 2 accepted, y stable, all 4 delivered in order, tx_cnt=4.
REQ-038 rst with pipeline full -> out_valid=0, tx_cnt=0, err_acc=0 next cycle; next beat latency again 2.
REQ-039 err_acc preloaded near 0xFFFFFFFF then err_abs=8 beat -> saturates at 0xFFFFFFFF; stats_clr with handshake -> err_acc = that beat's err_abs.
